// File: rtl/lmfe_sram_arb.sv
// LMFE line-SRAM arbiter: write FIFO + read stream onto one single-port SRAM.
// Define LMFE_ARB_STAT_EN to add the STALL_CNT/HAZ_CNT statistics ports.
module lmfe_sram_arb #(
   parameter int WF_DEPTH    = 4,
   parameter int WR_WAIT_MAX = 3
) (
   input  logic        clk,
   input  logic        RST_N,
   input  logic        WREQ,
   input  logic [9:0]  WA,
   input  logic [7:0]  WD,
   output logic        WFULL,
   output logic        WEMPTY,
   input  logic        RREQ,
   input  logic [9:0]  RA,
   output logic        RGNT,
   output logic        RVLD,
   output logic [7:0]  RQ,
   input  logic        FLUSH,
   output logic        FDONE,
   output logic [9:0]  A,
   output logic [7:0]  D,
   output logic        CEN,
   output logic        WEN,
   input  logic [7:0]  Q
`ifdef LMFE_ARB_STAT_EN
   ,
   output logic [15:0] STALL_CNT,
   output logic [15:0] HAZ_CNT
`endif
);

   localparam int PW = $clog2(WF_DEPTH);
   localparam int WW = $clog2(WR_WAIT_MAX + 1);
   localparam logic [PW:0]   FULL_CNT = (PW+1)'(WF_DEPTH);
   localparam logic [WW-1:0] WAIT_MAX = WW'(WR_WAIT_MAX);

   localparam logic [1:0] S_NORM  = 2'd0;
   localparam logic [1:0] S_DRAIN = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [9:0]    fa_q [WF_DEPTH];
   logic [7:0]    fd_q [WF_DEPTH];
   logic [PW-1:0] wp_q, wp_d;
   logic [PW-1:0] rp_q, rp_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [1:0]    st_q, st_d;
   logic          wfull_q, wempty_q, rvld_q;

   logic          push, pop, ne, hazard, force_wr, rd_gnt;
   logic [PW-1:0] off;

   assign ne   = (cnt_q != '0);
   assign push = WREQ && !wfull_q;

   // A read matching any queued address must wait until that entry is written
   always_comb begin
      hazard = 1'b0;
      off    = '0;
      for (int i = 0; i < WF_DEPTH; i++) begin
         off = PW'(i) - rp_q;
         if (({1'b0, off} < cnt_q) && (fa_q[i] == RA))
            hazard = 1'b1;
      end
      hazard = hazard && RREQ;
   end

   assign force_wr = ne && ((st_q == S_DRAIN) || wfull_q ||
                            (wait_q == WAIT_MAX) || hazard);
   assign pop      = ne && (force_wr || !RREQ);
   assign rd_gnt   = RREQ && !force_wr;

   always_comb begin
      CEN = 1'b1;
      WEN = 1'b1;
      A   = '0;
      D   = '0;
      if (RST_N && pop) begin
         CEN = 1'b0;
         WEN = 1'b0;
         A   = fa_q[rp_q];
         D   = fd_q[rp_q];
      end else if (RST_N && rd_gnt) begin
         CEN = 1'b0;
         A   = RA;
      end
   end

   assign RGNT   = RST_N && rd_gnt;
   assign RVLD   = rvld_q;
   assign RQ     = Q;
   assign WFULL  = wfull_q;
   assign WEMPTY = wempty_q;
   assign FDONE  = (st_q == S_DONE);

   assign cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
   assign wp_d  = wp_q + PW'(push);
   assign rp_d  = rp_q + PW'(pop);

   always_comb begin
      wait_d = wait_q;
      if (!ne || pop)
         wait_d = '0;
      else if (wait_q != WAIT_MAX)
         wait_d = wait_q + 1'b1;
   end

   always_comb begin
      st_d = st_q;
      case (st_q)
         S_NORM:  if (FLUSH) st_d = S_DRAIN;
         S_DRAIN: if (!ne && !push) st_d = S_DONE;
         S_DONE:  st_d = S_NORM;
         default: st_d = S_NORM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fa_q[wp_q] <= WA;
         fd_q[wp_q] <= WD;
      end
   end

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         wp_q     <= '0;
         rp_q     <= '0;
         cnt_q    <= '0;
         wait_q   <= '0;
         st_q     <= S_NORM;
         wfull_q  <= 1'b0;
         wempty_q <= 1'b1;
         rvld_q   <= 1'b0;
      end else begin
         wp_q     <= wp_d;
         rp_q     <= rp_d;
         cnt_q    <= cnt_d;
         wait_q   <= wait_d;
         st_q     <= st_d;
         wfull_q  <= (cnt_d == FULL_CNT);
         wempty_q <= (cnt_d == '0);
         rvld_q   <= rd_gnt;
      end
   end

`ifdef LMFE_ARB_STAT_EN
   logic [15:0] stall_q, haz_q;

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         stall_q <= '0;
         haz_q   <= '0;
      end else if (FDONE) begin
         stall_q <= '0;
         haz_q   <= '0;
      end else begin
         if (RREQ && !rd_gnt && stall_q != 16'hFFFF)
            stall_q <= stall_q + 1'b1;
         if (hazard && haz_q != 16'hFFFF)
            haz_q <= haz_q + 1'b1;
      end
   end

   assign STALL_CNT = stall_q;
   assign HAZ_CNT   = haz_q;
`endif

endmodule
